pulse_spacer: RTL and testbench
===============================

PULSE_SPACER -- requirements
Module: pulse_spacer

Interface
REQ-001 SHALL have parameter MIN_GAP, default 8: number of idle clk_fast cycles forced after every output pulse (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 4: width of the pending-event counter (legal range 1..8).
REQ-003 SHALL have port clk_fast  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port ev_in  in  1: event request; each cycle high counts as one event.
REQ-006 SHALL have port clear_ovf  in  1: synchronous clear of overflow.
REQ-007 SHALL have port pulse_out  out  1: registered single-cycle pulse, spaced for the downstream toggle synchronizer.
REQ-008 SHALL have port pending  out  CNT_W: events accepted but not yet issued.
REQ-009 SHALL have port busy  out  1: high when state is not IDLE or pending is non-zero.
REQ-010 SHALL have port overflow  out  1: sticky flag, set when an event is dropped.

Function
REQ-011 SHALL implement FSM states IDLE, FIRE, GAP; pulse_out is 1 only in FIRE, which always lasts exactly one cycle.
REQ-012 IDLE: if ev_in=1 or pending!=0, next state FIRE; else stay IDLE.
REQ-013 FIRE: next state GAP; gap counter loaded with MIN_GAP.
REQ-014 GAP: counter decrements each cycle; on the cycle it reaches 1, next state is FIRE if (pending!=0 or ev_in=1), else IDLE.
REQ-015 Latency: ev_in high in IDLE with pending=0 gives pulse_out high on the next cycle.
REQ-016 Under backlog, pulse_out rising edges SHALL be exactly MIN_GAP+1 cycles apart; no two pulses closer.
REQ-017 An event is consumed on the transition into FIRE; if pending=0 at that moment, the concurrent ev_in is the consumed event.
REQ-018 Pending update per cycle: +1 for an accepted ev_in not consumed directly, -1 for a FIRE entry taken from pending; both together leave pending unchanged.
REQ-019 Pending SHALL saturate at 2^CNT_W-1; an ev_in that would exceed it is dropped and sets overflow on the next cycle.
REQ-020 clear_ovf=1 clears overflow unless a drop occurs in the same cycle; set wins.
REQ-021 Events SHALL never be duplicated: pulses issued + events dropped + pending = events presented, at all times since reset.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, pulse_out=0, pending=0, overflow=0, gap counter=0, busy=0, regardless of clock.
REQ-023 Reset asserted mid-FIRE or mid-GAP SHALL discard all pending events; first pulse after release needs a new ev_in.
REQ-024 ev_in in the first clock edge after reset release SHALL be handled as in IDLE.

Configuration
REQ-025 Macro PULSE_SPACER_STATS_EN defined: SHALL add output drop_cnt (8 bits, saturating at 255), incremented per dropped event, reset to 0 by rst, unaffected by clear_ovf.
REQ-026 Macro PULSE_SPACER_STATS_EN undefined: drop_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Single event: MIN_GAP=8, ev_in high one cycle at T in IDLE -> pulse_out high at T+1 only, busy high T+1..T+9, IDLE at T+10, pending stays 0.
REQ-028 Burst: ev_in high at T, T+1, T+2 -> pending peaks at 2; pulses at T+1, T+10, T+19; overflow=0.
REQ-029 Overflow: CNT_W=2, ev_in high 5 consecutive cycles from IDLE -> pending saturates at 3, 1 event dropped, overflow=1, exactly 4 pulses; drop_cnt=1 with PULSE_SPACER_STATS_EN.
REQ-030 Clear race: clear_ovf=1 in the same cycle as a drop -> overflow stays 1; clear_ovf alone next cycle -> overflow 0.
REQ-031 Reset mid-GAP: pending=2, assert rst asynchronously between edges -> all outputs 0 immediately; no pulse after release without new ev_in.
REQ-032 Downstream check: drive pulse_out into the existing fast-to-slow toggle synchronizer at 4:1 clock ratio, MIN_GAP=8, 20 back-to-back events -> exactly 20 slow-domain pulses.

Source files
------------

// File: rtl/pulse_spacer_if.sv
// Event-request / spaced-pulse bundle for pulse_spacer.
// PULSE_SPACER_STATS_EN adds the drop_cnt statistics signal.
interface pulse_spacer_if #(
  parameter int unsigned CNT_W = 4
);
  logic             ev_in;
  logic             clear_ovf;
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;
`ifdef PULSE_SPACER_STATS_EN
  logic [7:0]       drop_cnt;

  modport master (output ev_in, clear_ovf, input pulse_out, pending, busy, overflow, drop_cnt);
  modport slave  (input ev_in, clear_ovf, output pulse_out, pending, busy, overflow, drop_cnt);
`else
  modport master (output ev_in, clear_ovf, input pulse_out, pending, busy, overflow);
  modport slave  (input ev_in, clear_ovf, output pulse_out, pending, busy, overflow);
`endif
endinterface

// File: rtl/pulse_spacer.sv
// Turns event requests into single-cycle pulses spaced MIN_GAP idle cycles apart,
// queueing a bounded backlog. PULSE_SPACER_STATS_EN adds a saturating drop counter.
module pulse_spacer #(
  parameter int unsigned MIN_GAP = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic          clk_fast,
  input  logic          rst,
  pulse_spacer_if.slave bus
);
  localparam int unsigned GAP_W = 8;
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, FIRE, GAP} state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0] pending_q, pending_nxt;
  logic             pulse_q, busy_q, overflow_q;
  logic             fire_entry_c, from_pend_c, direct_c, accept_c, drop_c;

  // Next-state and gap timer
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    unique case (state)
      IDLE: begin
        if (bus.ev_in || (pending_q != '0)) state_nxt = FIRE;
      end
      FIRE: begin
        state_nxt   = GAP;
        gap_cnt_nxt = GAP_W'(MIN_GAP);
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = (bus.ev_in || (pending_q != '0)) ? FIRE : IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        gap_cnt_nxt = '0;
      end
    endcase
  end

  // A FIRE entry consumes the backlog first; otherwise it consumes the concurrent ev_in
  always_comb begin
    fire_entry_c = (state_nxt == FIRE);
    from_pend_c  = fire_entry_c && (pending_q != '0);
    direct_c     = fire_entry_c && (pending_q == '0);
    accept_c     = bus.ev_in && !direct_c;
    drop_c       = accept_c && !from_pend_c && (pending_q == PEND_MAX);
    pending_nxt  = pending_q;
    if (from_pend_c && !accept_c) begin
      pending_nxt = pending_q - CNT_W'(1);
    end else if (!from_pend_c && accept_c && !drop_c) begin
      pending_nxt = pending_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      pending_q  <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_cnt_nxt;
      pending_q  <= pending_nxt;
      pulse_q    <= (state_nxt == FIRE);
      busy_q     <= (state_nxt != IDLE) || (pending_nxt != '0);
      overflow_q <= drop_c || (overflow_q && !bus.clear_ovf);
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;

`ifdef PULSE_SPACER_STATS_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_pulse_spacer.sv
// Self-checking bench for pulse_spacer against a timeline-based reference model.
module tb_pulse_spacer;
  localparam int unsigned MIN_GAP  = 8;
  localparam int unsigned CNT_W    = 2;
  localparam int          PEND_MAX = 3;

  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pulse_spacer_if #(.CNT_W(CNT_W)) bus ();

  pulse_spacer #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .bus      (bus)
  );

  always #5  clk_fast = ~clk_fast;
  always #20 clk_slow = ~clk_slow;

  // Model: a pulse may issue once MIN_GAP cycles have elapsed since the last one
  typedef struct {
    int cyc;
    int lp;
    int pend;
    int drops;
    int events;
    bit ovf;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.cyc = 0; r.lp = -1000; r.pend = 0; r.drops = 0; r.events = 0; r.ovf = 1'b0;
    return r;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit ev, bit clr);
    mstate_t n;
    bit fire;
    bit drop;
    n    = s;
    drop = 1'b0;
    fire = ((s.pend > 0) || ev) && ((s.cyc - s.lp) >= int'(MIN_GAP));
    if (ev) n.events = s.events + 1;
    if (fire) begin
      if (s.pend > 0) n.pend = s.pend - 1 + (ev ? 1 : 0);
    end else if (ev) begin
      if (s.pend == PEND_MAX) drop = 1'b1;
      else n.pend = s.pend + 1;
    end
    if (drop) n.drops = s.drops + 1;
    n.ovf = drop || (s.ovf && !clr);
    n.cyc = s.cyc + 1;
    if (fire) n.lp = n.cyc;
    return n;
  endfunction

  function automatic bit exp_pulse();
    return m.lp == m.cyc;
  endfunction

  function automatic bit exp_busy();
    return ((m.cyc - m.lp) <= int'(MIN_GAP)) || (m.pend != 0);
  endfunction

  always @(posedge clk_fast or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m, bus.ev_in, bus.clear_ovf);
  end

  // Pulses issued in completed cycles since reset
  int n_pulses;
  always @(posedge clk_fast or posedge rst) begin
    if (rst) n_pulses <= 0;
    else     n_pulses <= n_pulses + (bus.pulse_out ? 1 : 0);
  end

  // Downstream fast-to-slow toggle synchronizer
  logic       tog_fast;
  logic [2:0] sync_s;
  int         slow_pulses;
  always @(posedge clk_fast or posedge rst) begin
    if (rst) tog_fast <= 1'b0;
    else if (bus.pulse_out) tog_fast <= ~tog_fast;
  end
  always @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      sync_s      <= '0;
      slow_pulses <= 0;
    end else begin
      sync_s <= {sync_s[1:0], tog_fast};
      if (sync_s[2] ^ sync_s[1]) slow_pulses <= slow_pulses + 1;
    end
  end

  task automatic cycle(input logic ev, input logic clr);
    bus.ev_in     = ev;
    bus.clear_ovf = clr;
    @(posedge clk_fast);
    @(negedge clk_fast);
  endtask

  task automatic do_reset();
    @(negedge clk_fast);
    bus.ev_in     = 1'b0;
    bus.clear_ovf = 1'b0;
    rst = 1'b1;
    @(negedge clk_fast);
    rst = 1'b0;
    repeat (2) cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.ev_in     = 1'b0;
    bus.clear_ovf = 1'b0;
    repeat (2) @(negedge clk_fast);
    total++; if (bus.pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", bus.pulse_out); end
    total++; if (bus.pending !== '0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", bus.pending); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    rst = 1'b0;
    repeat (2) cycle(1'b0, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    cycle(1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      total++; if (bus.pulse_out !== 1'(k == 1)) begin bad++; $display("FAIL single_pulse T+%0d got=%b exp=%b", k, bus.pulse_out, k == 1); end
      total++; if (bus.busy !== 1'(k <= 9)) begin bad++; $display("FAIL single_busy T+%0d got=%b exp=%b", k, bus.busy, k <= 9); end
      total++; if (bus.pending !== '0) begin bad++; $display("FAIL single_pending T+%0d got=%0d exp=0", k, bus.pending); end
      cycle(1'b0, 1'b0);
    end
  endtask

  task automatic test_burst();
    int pcyc[$];
    int peak;
    peak = 0;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      cycle(1'(k < 3), 1'b0);
      if (bus.pulse_out === 1'b1) pcyc.push_back(k + 1);
      if (int'(bus.pending) > peak) peak = int'(bus.pending);
    end
    total++;
    if (pcyc.size() != 3) begin
      bad++; $display("FAIL burst_count got=%0d exp=3", pcyc.size());
    end else begin
      total++; if (pcyc[0] != 1)  begin bad++; $display("FAIL burst_p0 got=T+%0d exp=T+1", pcyc[0]); end
      total++; if (pcyc[1] != 10) begin bad++; $display("FAIL burst_p1 got=T+%0d exp=T+10", pcyc[1]); end
      total++; if (pcyc[2] != 19) begin bad++; $display("FAIL burst_p2 got=T+%0d exp=T+19", pcyc[2]); end
    end
    total++; if (peak != 2) begin bad++; $display("FAIL burst_peak got=%0d exp=2", peak); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL burst_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_overflow();
    int pulses;
    int peak;
    pulses = 0;
    peak   = 0;
    do_reset();
    for (int k = 0; k < 45; k++) begin
      cycle(1'(k < 5), 1'b0);
      if (bus.pulse_out === 1'b1) pulses++;
      if (int'(bus.pending) > peak) peak = int'(bus.pending);
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL ovf_pulses got=%0d exp=4", pulses); end
    total++; if (peak != PEND_MAX) begin bad++; $display("FAIL ovf_peak got=%0d exp=%0d", peak, PEND_MAX); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    total++; if (bus.pending !== '0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", bus.pending); end
`ifdef PULSE_SPACER_STATS_EN
    total++; if (bus.drop_cnt !== 8'd1) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=1", bus.drop_cnt); end
`endif
  endtask

  task automatic test_clear_race();
    do_reset();
    repeat (4) cycle(1'b1, 1'b0);
    total++; if (bus.pending !== CNT_W'(PEND_MAX)) begin bad++; $display("FAIL race_prefill got=%0d exp=%0d", bus.pending, PEND_MAX); end
    cycle(1'b1, 1'b1);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL race_set_wins got=%b exp=1", bus.overflow); end
    cycle(1'b0, 1'b1);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL race_clear got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_reset_mid_gap();
    int pulses;
    pulses = 0;
    do_reset();
    repeat (3) cycle(1'b1, 1'b0);
    bus.ev_in = 1'b0;
    total++; if (bus.pending !== CNT_W'(2)) begin bad++; $display("FAIL midgap_pending got=%0d exp=2", bus.pending); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.pulse_out !== 1'b0) begin bad++; $display("FAIL midgap_pulse got=%b exp=0", bus.pulse_out); end
    total++; if (bus.pending !== '0) begin bad++; $display("FAIL midgap_pend0 got=%0d exp=0", bus.pending); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midgap_busy got=%b exp=0", bus.busy); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL midgap_ovf got=%b exp=0", bus.overflow); end
    @(negedge clk_fast);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b0, 1'b0);
      if (bus.pulse_out === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midgap_ghost got=%0d exp=0", pulses); end
    // ev_in present on the very first edge after release
    rst = 1'b1;
    @(negedge clk_fast);
    rst = 1'b0;
    cycle(1'b1, 1'b0);
    total++; if (bus.pulse_out !== 1'b1) begin bad++; $display("FAIL release_first got=%b exp=1", bus.pulse_out); end
    bus.ev_in = 1'b0;
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    dens = 10;
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) dens = int'($urandom_range(5, 95));
      cycle(1'(int'($urandom_range(0, 99)) < dens), 1'($urandom_range(0, 9) == 0));
      total++; if (bus.pulse_out !== exp_pulse()) begin bad++; $display("FAIL rnd_pulse cyc=%0d got=%b exp=%b", m.cyc, bus.pulse_out, exp_pulse()); end
      total++; if (bus.pending !== CNT_W'(m.pend)) begin bad++; $display("FAIL rnd_pending cyc=%0d got=%0d exp=%0d", m.cyc, bus.pending, m.pend); end
      total++; if (bus.busy !== exp_busy()) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", m.cyc, bus.busy, exp_busy()); end
      total++; if (bus.overflow !== m.ovf) begin bad++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", m.cyc, bus.overflow, m.ovf); end
      total++;
      if (n_pulses + (bus.pulse_out ? 1 : 0) + m.drops + int'(bus.pending) != m.events) begin
        bad++; $display("FAIL rnd_conserve cyc=%0d issued=%0d dropped=%0d pending=%0d events=%0d",
                        m.cyc, n_pulses + (bus.pulse_out ? 1 : 0), m.drops, bus.pending, m.events);
      end
`ifdef PULSE_SPACER_STATS_EN
      total++; if (int'(bus.drop_cnt) != ((m.drops > 255) ? 255 : m.drops)) begin bad++; $display("FAIL rnd_drop_cnt got=%0d exp=%0d", bus.drop_cnt, m.drops); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int   fed;
    int   last;
    int   fast;
    int   slow_base;
    logic ev;
    fed  = 0;
    last = -1;
    fast = 0;
    do_reset();
    repeat (3) @(posedge clk_slow);
    @(negedge clk_fast);
    slow_base = slow_pulses;
    for (int k = 0; k < 400; k++) begin
      ev = 1'((fed < 20) && (m.pend < 2));
      if (ev) fed++;
      cycle(ev, 1'b0);
      if (bus.pulse_out === 1'b1) begin
        if (last >= 0) begin
          total++; if (k + 1 - last != int'(MIN_GAP) + 1) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", k + 1 - last, MIN_GAP + 1); end
        end
        last = k + 1;
        fast++;
      end
    end
    repeat (4) @(posedge clk_slow);
    @(negedge clk_fast);
    total++; if (fast != 20) begin bad++; $display("FAIL b2b_fast got=%0d exp=20", fast); end
    total++; if (slow_pulses - slow_base != 20) begin bad++; $display("FAIL b2b_slow got=%0d exp=20", slow_pulses - slow_base); end
  endtask

  initial begin
    bus.ev_in     = 1'b0;
    bus.clear_ovf = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_clear_race();
    test_reset_mid_gap();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
